// File: rtl/intel_vvp_icon_axi_zero_strip.sv
// intel_vvp_icon_axi_zero_strip
// Removes the byte-padding added by the ICON zero-pad stage. Each pixel is
// narrowed back to BPS*NUMBER_OF_COLOR_PLANES bits and tuser to its kept LSBs.
// A registered slice (output register plus one-entry skid) keeps full
// throughput while s_axis_tready stays a flop output. Beats carrying nonzero
// pad bits or nonzero dropped tuser bits are still forwarded. Such beats are
// also counted, and raise a sticky flag.
module intel_vvp_icon_axi_zero_strip #(
  parameter int BPS                    = 10,
  parameter int NUMBER_OF_COLOR_PLANES = 3,
  parameter int PIXELS_IN_PARALLEL     = 2,
  // Kept tuser width, same value as intel_vvp_icon_pkg::VVP_USER_KEEP_BITS
  localparam int VVP_USER_KEEP_BITS    = 2,
  localparam int PW   = BPS * NUMBER_OF_COLOR_PLANES,
  localparam int PB   = (((PW + 7) / 8) < 2) ? 2 : ((PW + 7) / 8),
  localparam int PWP  = 8 * PB,
  localparam int DIN  = PWP * PIXELS_IN_PARALLEL,
  localparam int DOUT = PW * PIXELS_IN_PARALLEL,
  localparam int UIN  = PB * PIXELS_IN_PARALLEL
) (
  input  logic                          clock,
  input  logic                          areset_n,
  input  logic [DIN-1:0]                s_axis_tdata,
  input  logic [UIN-1:0]                s_axis_tuser,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DOUT-1:0]               m_axis_tdata,
  output logic [VVP_USER_KEEP_BITS-1:0] m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  input  logic                          clear_error,
  output logic                          pad_error,
  output logic [15:0]                   pad_err_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   tready_reg;

  logic [DOUT-1:0]               strip_data;
  logic [PIXELS_IN_PARALLEL-1:0] pad_nz;
  logic                          user_nz;
  logic                          bad_beat;

  logic [DOUT-1:0]               out_data_reg, skid_data_reg;
  logic [VVP_USER_KEEP_BITS-1:0] out_user_reg, skid_user_reg;
  logic                          out_last_reg, skid_last_reg;
  logic                          pad_error_reg;
  logic [15:0]                   pad_err_count_reg;

  logic accept, emit;
  logic load_out_in, load_out_skid, load_skid;

  assign accept = s_axis_tvalid & tready_reg;
  assign emit   = (state_reg != ST_EMPTY) & m_axis_tready;

  // Per-pixel strip and pad-bit inspection
  genvar gi;
  generate
    for (gi = 0; gi < PIXELS_IN_PARALLEL; gi++) begin : g_pix
      assign strip_data[gi*PW +: PW] = s_axis_tdata[gi*PWP +: PW];
      if (PWP > PW) begin : g_pad
        assign pad_nz[gi] = |s_axis_tdata[gi*PWP+PW +: PWP-PW];
      end else begin : g_nopad
        assign pad_nz[gi] = 1'b0;
      end
    end
    if (UIN > VVP_USER_KEEP_BITS) begin : g_user_drop
      assign user_nz = |s_axis_tuser[UIN-1:VVP_USER_KEEP_BITS];
    end else begin : g_user_keep
      assign user_nz = 1'b0;
    end
  endgenerate

  assign bad_beat = accept & ((|pad_nz) | user_nz);

  // Slice next-state and register load selection
  always_comb begin
    state_next    = state_reg;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next  = ST_ONE;
          load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !emit) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (emit && !accept) begin
          state_next = ST_EMPTY;
        end else if (emit && accept) begin
          load_out_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_next    = ST_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Slice state and registered ready (low whenever the slice will be full)
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_reg  <= ST_EMPTY;
      tready_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tready_reg <= (state_next != ST_FULL);
    end
  end

  // Output register and skid entry, holding stripped width only
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      out_data_reg  <= '0;
      out_user_reg  <= '0;
      out_last_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_user_reg <= '0;
      skid_last_reg <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_data_reg <= strip_data;
        out_user_reg <= s_axis_tuser[VVP_USER_KEEP_BITS-1:0];
        out_last_reg <= s_axis_tlast;
      end else if (load_out_skid) begin
        out_data_reg <= skid_data_reg;
        out_user_reg <= skid_user_reg;
        out_last_reg <= skid_last_reg;
      end
      if (load_skid) begin
        skid_data_reg <= strip_data;
        skid_user_reg <= s_axis_tuser[VVP_USER_KEEP_BITS-1:0];
        skid_last_reg <= s_axis_tlast;
      end
    end
  end

  // Sticky error flag and saturating bad-beat counter; a bad beat arriving
  // together with clear_error still counts as the first one after the clear
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      pad_error_reg     <= 1'b0;
      pad_err_count_reg <= 16'd0;
    end else if (clear_error) begin
      pad_error_reg     <= bad_beat;
      pad_err_count_reg <= bad_beat ? 16'd1 : 16'd0;
    end else if (bad_beat) begin
      pad_error_reg <= 1'b1;
      if (pad_err_count_reg != 16'hFFFF) begin
        pad_err_count_reg <= pad_err_count_reg + 16'd1;
      end
    end
  end

  assign s_axis_tready = tready_reg;
  assign m_axis_tvalid = (state_reg != ST_EMPTY);
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tuser  = out_user_reg;
  assign m_axis_tlast  = out_last_reg;
  assign pad_error     = pad_error_reg;
  assign pad_err_count = pad_err_count_reg;

endmodule

// File: tb/tb_intel_vvp_icon_axi_zero_strip.sv
// Testbench for intel_vvp_icon_axi_zero_strip (BPS=10, NCP=3, PIP=2).
// A queue of expected beats is built from the stripping rule with plain
// arithmetic. The expected error count is modelled from the bad-beat rule.
module tb_intel_vvp_icon_axi_zero_strip;

  logic        clock = 1'b0;
  logic        areset_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [59:0] m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        clear_error;
  logic        pad_error;
  logic [15:0] pad_err_count;

  intel_vvp_icon_axi_zero_strip dut (
    .clock         (clock),
    .areset_n      (areset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .clear_error   (clear_error),
    .pad_error     (pad_error),
    .pad_err_count (pad_err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [59:0] d;
    logic [1:0]  u;
    logic        l;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  logic [15:0] cnt_m;
  logic        err_m;
  logic        stall_prev;
  beat_t       stall_beat;

  // Expected output beat: low 30 bits of each 32-bit pixel, repacked at 30-bit pitch
  function automatic beat_t model(input logic [63:0] d, input logic [7:0] u, input logic l);
    beat_t b;
    logic [63:0] p0, p1;
    p0 = d % 64'h1_0000_0000;
    p1 = d / 64'h1_0000_0000;
    b.d = 60'((p0 % 64'h4000_0000) + (p1 % 64'h4000_0000) * 64'h4000_0000);
    b.u = 2'(u % 8'd4);
    b.l = l;
    return b;
  endfunction

  // A beat is bad when any pixel does not fit in 30 bits or tuser does not fit in 2 bits
  function automatic bit is_bad(input logic [63:0] d, input logic [7:0] u);
    logic [63:0] p0, p1;
    p0 = d % 64'h1_0000_0000;
    p1 = d / 64'h1_0000_0000;
    return (p0 >= 64'h4000_0000) || (p1 >= 64'h4000_0000) || (u >= 8'd4);
  endfunction

  // One clock of stimulus starting at a negedge; scoreboards the handshake
  // that happens at the following posedge and ends on the next negedge.
  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] u,
                       input logic l, input logic mr, input logic clr,
                       output bit acc, output bit emt);
    beat_t got, e;
    bit bad;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    m_axis_tready = mr;
    clear_error   = clr;
    #1;
    acc = s_axis_tvalid && s_axis_tready;
    emt = m_axis_tvalid && m_axis_tready;
    got = '{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast};
    if (stall_prev) begin
      checks++;
      if (!m_axis_tvalid || got !== stall_beat) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b %h/%h/%0b required v=1 %h/%h/%0b",
                 m_axis_tvalid, got.d, got.u, got.l, stall_beat.d, stall_beat.u, stall_beat.l);
      end
    end
    stall_prev = m_axis_tvalid && !m_axis_tready;
    stall_beat = got;
    if (emt) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h/%h/%0b required none", got.d, got.u, got.l);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got %h/%h/%0b required %h/%h/%0b",
                   got.d, got.u, got.l, e.d, e.u, e.l);
        end
      end
    end
    bad = 1'b0;
    if (acc) begin
      exp_q.push_back(model(d, u, l));
      bad = is_bad(d, u);
    end
    if (clr) begin
      cnt_m = bad ? 16'd1 : 16'd0;
      err_m = bad;
    end else if (bad) begin
      err_m = 1'b1;
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (pad_err_count !== cnt_m || pad_error !== err_m) begin
      errors++;
      $display("FAIL err_state: got count=%h err=%0b required count=%h err=%0b",
               pad_err_count, pad_error, cnt_m, err_m);
    end
    $display("cycle acc=%0b emt=%0b v=%0b d=%h u=%h l=%0b mr=%0b clr=%0b cnt=%h",
             acc, emt, v, d, u, l, mr, clr, pad_err_count);
  endtask

  task automatic idle(input logic mr);
    bit a, e;
    drive(1'b0, 64'd0, 8'd0, 1'b0, mr, 1'b0, a, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats left required 0", exp_q.size());
    end
    idle(1'b1);
  endtask

  function automatic logic [63:0] rand_clean();
    logic [31:0] a, b;
    a = 32'($urandom_range(0, 32'h3FFF_FFFF));
    b = 32'($urandom_range(0, 32'h3FFF_FFFF));
    return {a, b};
  endfunction

  task automatic test_reset();
    areset_n      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    clear_error   = 1'b0;
    cnt_m = 16'd0; err_m = 1'b0; stall_prev = 1'b0;
    #2;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== 60'd0 ||
        m_axis_tuser !== 2'd0 || m_axis_tlast !== 1'b0 || pad_error !== 1'b0 || pad_err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b rdy=%0b d=%h u=%h l=%0b err=%0b cnt=%h required all zero",
               m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tlast, pad_error, pad_err_count);
    end
    repeat (2) @(negedge clock);
    areset_n = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %0b required 0", s_axis_tready);
    end
    @(negedge clock);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %0b required 1", s_axis_tready);
    end
    $display("reset done");
  endtask

  task automatic test_single();
    bit a, e;
    drive(1'b1, {32'h0000_0001, 32'h3FFF_FFFF}, 8'h03, 1'b1, 1'b1, 1'b0, a, e);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 60'h0000000_7FFF_FFFF ||
        m_axis_tuser !== 2'b11 || m_axis_tlast !== 1'b1 || pad_error !== 1'b0) begin
      errors++;
      $display("FAIL single_beat: got v=%0b d=%h u=%b l=%0b err=%0b required 1 00000007fffffff 11 1 0",
               m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, pad_error);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit a, e;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1'b1, rand_clean(), 8'($urandom_range(0, 3)), (k == 7), 1'b1, 1'b0, a, e);
      else       idle(1'b1);
      checks++;
      if ((k < 8 && !a) || (k > 0 && !e)) begin
        errors++;
        $display("FAIL back_to_back: beat %0d got acc=%0b emt=%0b required acc=%0b emt=%0b",
                 k, a, e, (k < 8), (k > 0));
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit a, e;
    int nacc;
    logic [63:0] d [3];
    for (int k = 0; k < 3; k++) d[k] = rand_clean();
    nacc = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, d[nacc], 8'(k), (k == 2), 1'b0, 1'b0, a, e);
      if (a) nacc++;
    end
    checks++;
    if (nacc != 2 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_fill: got accepted=%0d ready=%0b required accepted=2 ready=0",
               nacc, s_axis_tready);
    end
    for (int k = 0; k < 6 && nacc < 3; k++) begin
      drive(1'b1, d[2], 8'd2, 1'b1, 1'b1, 1'b0, a, e);
      if (a) nacc++;
    end
    checks++;
    if (nacc != 3) begin
      errors++;
      $display("FAIL backpressure_resume: got accepted=%0d required 3", nacc);
    end
    drain();
  endtask

  task automatic test_pad_error();
    bit a, e;
    drive(1'b1, {32'h4000_0000, 32'h0000_1234}, 8'h00, 1'b0, 1'b1, 1'b0, a, e);
    checks++;
    if (m_axis_tdata !== 60'h0000000_0000_1234 || pad_error !== 1'b1 || pad_err_count !== 16'd1) begin
      errors++;
      $display("FAIL pad_bit: got d=%h err=%0b cnt=%h required 000000000001234 1 0001",
               m_axis_tdata, pad_error, pad_err_count);
    end
    drive(1'b1, 64'h0000_0001_0000_0002, 8'h04, 1'b1, 1'b1, 1'b0, a, e);
    checks++;
    if (pad_err_count !== 16'd2) begin
      errors++;
      $display("FAIL user_drop: got cnt=%h required 0002", pad_err_count);
    end
    drive(1'b0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b1, a, e);
    checks++;
    if (pad_error !== 1'b0 || pad_err_count !== 16'd0) begin
      errors++;
      $display("FAIL clear: got err=%0b cnt=%h required 0 0000", pad_error, pad_err_count);
    end
    drive(1'b1, 64'h8000_0000_0000_0000, 8'h00, 1'b0, 1'b1, 1'b0, a, e);
    drive(1'b1, 64'h0000_0000_8000_0000, 8'h00, 1'b0, 1'b1, 1'b1, a, e);
    checks++;
    if (pad_error !== 1'b1 || pad_err_count !== 16'd1) begin
      errors++;
      $display("FAIL clear_with_bad: got err=%0b cnt=%h required 1 0001", pad_error, pad_err_count);
    end
    drive(1'b0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b1, a, e);
    drain();
  endtask

  task automatic test_saturate();
    bit a, e;
    force dut.pad_err_count_reg = 16'hFFFE;
    #1;
    release dut.pad_err_count_reg;
    cnt_m = 16'hFFFE;
    for (int k = 0; k < 3; k++)
      drive(1'b1, 64'h0000_0000_4000_0000, 8'h80, 1'b0, 1'b1, 1'b0, a, e);
    checks++;
    if (pad_err_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate: got cnt=%h required ffff", pad_err_count);
    end
    drive(1'b0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b1, a, e);
    drain();
  endtask

  task automatic test_random();
    bit a, e;
    logic [63:0] d;
    logic [7:0]  u;
    for (int k = 0; k < 200; k++) begin
      d = rand_clean();
      u = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: d = d | 64'h8000_0000_0000_0000;
        1: d = d | 64'h0000_0000_4000_0000;
        2: u = u | 8'h20;
        default: ;
      endcase
      drive(($urandom_range(0, 9) < 7), d, u, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0), a, e);
    end
    drain();
  endtask

  task automatic test_reset_midpacket();
    bit a, e;
    drive(1'b1, 64'h0000_0000_4000_0000, 8'h00, 1'b0, 1'b0, 1'b0, a, e);
    drive(1'b1, rand_clean(), 8'h01, 1'b0, 1'b0, 1'b0, a, e);
    areset_n = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || pad_error !== 1'b0 || pad_err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_midpacket: got v=%0b rdy=%0b err=%0b cnt=%h required 0 0 0 0000",
               m_axis_tvalid, s_axis_tready, pad_error, pad_err_count);
    end
    exp_q.delete();
    stall_prev = 1'b0;
    cnt_m = 16'd0;
    err_m = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clock);
    areset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL recover: got rdy=%0b v=%0b required 1 0", s_axis_tready, m_axis_tvalid);
    end
    for (int k = 0; k < 4; k++)
      drive(1'b1, rand_clean(), 8'(k % 4), (k == 3), 1'b1, 1'b0, a, e);
    drain();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_pad_error();
    test_saturate();
    test_random();
    test_reset_midpacket();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
